bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
Sequential converter from packed multi-digit BCD to binary. It is the reverse path of the board's binary-to-BCD display logic: operator-entered decimal digits from SW become binary operands for the arithmetic blocks. It uses the reverse double-dabble method (shift right, then subtract 3 from any digit >= 8), with one bit per clock and a start/done handshake.

Parameters:
NDIGITS, 3, number of BCD digits on bcd_in; digit 0 is the least significant, in bcd_in[3:0].
BIN_W, 10, width of bin_out; it must satisfy 2^BIN_W >= 10^NDIGITS (3→10, 2→7, 4→14). A smaller value is a configuration error and its results are undefined.

Ports:
Clock  input  1  single system clock, rising edge.
Resetn  input  1  asynchronous, active-low reset.
start  input  1  request a conversion; sampled only in IDLE.
bcd_in  input  4*NDIGITS  packed BCD operand; sampled on the accepting edge only.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle completion pulse.
err  output  1  one-cycle pulse coincident with done when the operand is invalid.
bin_out  output  BIN_W  result; held until the next completion.

Behaviour:
- Reset (async, Resetn=0):
  - state=IDLE; busy=0, done=0, err=0, bin_out=0.
  - Shift register and counter cleared.
  - Reset mid-conversion aborts the operation; no done is issued.
- Registers:
  - sr = {bcd[4*NDIGITS-1:0], bin[BIN_W-1:0]}.
  - cnt counts 0..BIN_W-1 (width clog2(BIN_W)+1).
- States: IDLE, SHIFT.
- IDLE, start=1, all digits <= 9 (edge E0):
  - bcd part <= bcd_in, bin part <= 0, cnt <= 0, state <= SHIFT.
- IDLE, start=1, any digit > 9 (edge E0):
  - done <= 1, err <= 1, bin_out <= 0.
  - Stay in IDLE; no shifting.
- SHIFT, each edge E1..E_BIN_W:
  - t = sr >> 1 (zero fills the MSB).
  - Then every 4-bit digit of t's BCD part that is >= 8 has 3 subtracted; all digits are corrected in parallel in the same cycle.
  - sr <= corrected t; cnt <= cnt+1.
- Final shift (cnt == BIN_W-1):
  - bin_out <= bin part of the corrected t; done <= 1, err <= 0, state <= IDLE.
- Latency: done is high during the cycle after edge E_BIN_W, which is exactly BIN_W clocks after the accepting edge. That is 10 clocks for the defaults. The error path takes 1 clock.
- done and err are cleared on every edge where they are not set; they never stay high for 2 consecutive cycles from a single request.
- busy = (state == SHIFT). It rises after E0 and falls after E_BIN_W.
- start while busy=1 is ignored: no queueing and no restart. bcd_in changes during SHIFT have no effect.
- Back-to-back: start may be high in the same cycle as done, because state is already IDLE. That start is accepted, so throughput is one conversion per BIN_W+1 clocks with start held high.
- bin_out changes only on a completion edge, or to 0 on an error completion or reset.
- Leading zero digits are legal. An all-zero input produces 0 after the full BIN_W cycles; there is no early exit.
- Outputs are registered; there are no combinational paths from start or bcd_in to any output.

Test Plan:
- Reset; bcd_in=12'h999, start pulse -> busy for 10 cycles; done=1 exactly 10 clocks after the accepting edge with bin_out=10'd999 (1111100111), err=0; done low the next cycle.
- Convert 12'h000, 12'h010, 12'h128, 12'h500 -> bin_out 0, 10, 128, 500; each done 10 clocks after its start.
- bcd_in=12'h1A3, start -> done=1 and err=1 one clock later; bin_out=0; busy never asserted.
- Start 12'h456; at cycle 4 of SHIFT, pulse start with bcd_in=12'h111 -> ignored; result is 456 at cycle 10 and only one done occurs.
- Start 12'h777; drop Resetn at cycle 5 -> outputs go to 0 immediately; no done; a subsequent start with 12'h321 yields 321.
- NDIGITS=2, BIN_W=7; start held high continuously with bcd_in=8'h99 then 8'h42 -> done every 8 clocks; bin_out 99 then 42.

Source files
------------

// File: rtl/bcd_to_bin_seq_if.sv
// rtl/bcd_to_bin_seq_if.sv - start/done handshake and operand/result bundle for bcd_to_bin_seq
interface bcd_to_bin_seq_if #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
);
    logic                   start;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [BIN_W-1:0]       bin_out;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  err,
        input  bin_out
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output err,
        output bin_out
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - packed BCD to binary converter, reverse double-dabble, one bit per clock
module bcd_to_bin_seq #(
    parameter int NDIGITS = 3,
    parameter int BIN_W   = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bcd_to_bin_seq_if.slave bus
);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            r_state;
    logic [SR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [BIN_W-1:0]  r_bin;

    logic [SR_W-1:0]   w_shift;
    logic [SR_W-1:0]   w_next;
    logic              w_invalid;
    logic              w_last;

    // Shift right, then pull every BCD digit that went >= 8 back by 3, all digits in parallel.
    always_comb begin
        w_shift = r_sr >> 1;
        w_next  = w_shift;
        for (int d = 0; d < NDIGITS; d++) begin
            if (w_shift[BIN_W + 4*d +: 4] >= 4'd8) begin
                w_next[BIN_W + 4*d +: 4] = w_shift[BIN_W + 4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        w_invalid = 1'b0;
        for (int d = 0; d < NDIGITS; d++) begin
            if (bus.bcd_in[4*d +: 4] > 4'd9) begin
                w_invalid = 1'b1;
            end
        end
    end

    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bin   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_invalid) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                            r_bin  <= '0;
                        end else begin
                            r_sr    <= {bus.bcd_in, {BIN_W{1'b0}}};
                            r_cnt   <= '0;
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bin   <= w_next[BIN_W-1:0];
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.bin_out = r_bin;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - directed self-checking bench for bcd_to_bin_seq (3-digit and 2-digit builds)
module tb_bcd_to_bin_seq;
    logic clk;
    logic rst_n;

    int n_asserts;
    int n_fail;

    bcd_to_bin_seq_if #(.NDIGITS(3), .BIN_W(10)) if3 ();
    bcd_to_bin_seq_if #(.NDIGITS(2), .BIN_W(7))  if2 ();

    bcd_to_bin_seq #(.NDIGITS(3), .BIN_W(10)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if3.slave)
    );

    bcd_to_bin_seq #(.NDIGITS(2), .BIN_W(7)) dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one request on the 3-digit unit and watch a fixed 14-cycle window after the accepting edge.
    // exp_done_k is the index of the falling edge (1 = right after the accepting edge) where done shows.
    task automatic convert(input string tag, input logic [11:0] bcd,
                           input logic [31:0] exp_bin, input logic [31:0] exp_err,
                           input logic [31:0] exp_done_k, input logic [31:0] exp_busy,
                           input int inject_k);
        int done_k;
        int n_done;
        int n_busy;
        logic [31:0] err_at_done;
        logic [31:0] bin_at_done;
        done_k = 0;
        n_done = 0;
        n_busy = 0;
        err_at_done = 32'hFFFF_FFFF;
        bin_at_done = 32'hFFFF_FFFF;
        @(negedge clk);
        if3.start  = 1'b1;
        if3.bcd_in = bcd;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == inject_k) begin
                if3.start  = 1'b1;
                if3.bcd_in = 12'h111;
            end else begin
                if3.start = 1'b0;
            end
            if (if3.busy === 1'b1) n_busy++;
            if (if3.done === 1'b1) begin
                n_done++;
                if (done_k == 0) begin
                    done_k      = k;
                    err_at_done = 32'(if3.err);
                    bin_at_done = 32'(if3.bin_out);
                end
            end
        end
        chk({tag, "_done_k"}, 32'(done_k), exp_done_k);
        chk({tag, "_n_done"}, 32'(n_done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(n_busy), exp_busy);
        chk({tag, "_err"}, err_at_done, exp_err);
        chk({tag, "_bin"}, bin_at_done, exp_bin);
        chk({tag, "_bin_hold"}, 32'(if3.bin_out), exp_bin);
    endtask

    initial begin
        int first_k;
        int second_k;
        int n_done;
        logic [31:0] first_bin;
        logic [31:0] second_bin;
        n_asserts  = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        if3.start  = 1'b0;
        if3.bcd_in = '0;
        if2.start  = 1'b0;
        if2.bcd_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(if3.busy), 32'd0);
        chk("rst_done", 32'(if3.done), 32'd0);
        chk("rst_err",  32'(if3.err),  32'd0);
        chk("rst_bin",  32'(if3.bin_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Valid conversions: done after edge E10 shows at falling edge 11; busy over falling edges 1..10.
        convert("c999", 12'h999, 32'd999, 32'd0, 32'd11, 32'd10, 0);
        convert("c000", 12'h000, 32'd0,   32'd0, 32'd11, 32'd10, 0);
        convert("c010", 12'h010, 32'd10,  32'd0, 32'd11, 32'd10, 0);
        convert("c128", 12'h128, 32'd128, 32'd0, 32'd11, 32'd10, 0);
        convert("c500", 12'h500, 32'd500, 32'd0, 32'd11, 32'd10, 0);

        // Invalid digit: immediate done+err, result cleared, never busy.
        convert("c1A3", 12'h1A3, 32'd0, 32'd1, 32'd1, 32'd0, 0);

        // Start during SHIFT must be ignored.
        convert("c456", 12'h456, 32'd456, 32'd0, 32'd11, 32'd10, 4);

        // Reset mid-conversion aborts silently.
        @(negedge clk);
        if3.start  = 1'b1;
        if3.bcd_in = 12'h777;
        @(posedge clk);
        @(negedge clk);
        if3.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(if3.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(if3.busy), 32'd0);
        chk("abort_done", 32'(if3.done), 32'd0);
        chk("abort_bin",  32'(if3.bin_out), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (if3.done === 1'b1) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        convert("c321", 12'h321, 32'd321, 32'd0, 32'd11, 32'd10, 0);

        // 2-digit build, start held high: a completion every BIN_W+1 = 8 clocks.
        @(negedge clk);
        if2.start  = 1'b1;
        if2.bcd_in = 8'h99;
        @(posedge clk);
        first_k    = 0;
        second_k   = 0;
        first_bin  = 32'hFFFF_FFFF;
        second_bin = 32'hFFFF_FFFF;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) if2.bcd_in = 8'h42;
            if (if2.done === 1'b1) begin
                if (first_k == 0) begin
                    first_k   = k;
                    first_bin = 32'(if2.bin_out);
                end else if (second_k == 0) begin
                    second_k   = k;
                    second_bin = 32'(if2.bin_out);
                end
            end
        end
        if2.start = 1'b0;
        chk("b2b_first_k",   32'(first_k),  32'd8);
        chk("b2b_first_bin", first_bin,     32'd99);
        chk("b2b_second_k",  32'(second_k), 32'd16);
        chk("b2b_second_bin", second_bin,   32'd42);
        chk("b2b_dut3_quiet", 32'(if3.bin_out), 32'd321);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
